// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-synchronised line, mid-bit sampling, LSB first.
// Delivers each byte with a one-cycle valid strobe and flags bad stop bits.
module uart_rx #(
    parameter int unsigned SYS_CLOCK     = 50000000,
    parameter int unsigned UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_FrameErr,
    output logic       o_RxBusy
);

    localparam int unsigned MAX_CYCLE_CNT  = ((SYS_CLOCK * 10 / UART_BAUDRATE + 5) / 10) - 1;
    localparam int unsigned HALF_CYCLE_CNT = MAX_CYCLE_CNT / 2;
    localparam int unsigned CNT_W          = $clog2(MAX_CYCLE_CNT) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CNT_W-1:0] cycle_count;
    logic [2:0]       bit_count;
    logic [7:0]       shift_reg;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_RxSerial};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            state       <= IDLE;
            cycle_count <= '0;
            bit_count   <= '0;
            shift_reg   <= '0;
            o_RxByte    <= '0;
            o_RxValid   <= 1'b0;
            o_FrameErr  <= 1'b0;
            o_RxBusy    <= 1'b0;
        end else begin
            o_RxValid  <= 1'b0;
            o_FrameErr <= 1'b0;

            case (state)
                IDLE: begin
                    cycle_count <= '0;
                    if (!rx_s) begin
                        state    <= START_BIT;
                        o_RxBusy <= 1'b1;
                    end
                end

                // Re-check the line half a bit in to reject short glitches
                START_BIT: begin
                    if (cycle_count == CNT_W'(HALF_CYCLE_CNT)) begin
                        cycle_count <= '0;
                        if (!rx_s) begin
                            state     <= DATA_BITS;
                            bit_count <= '0;
                        end else begin
                            state    <= IDLE;
                            o_RxBusy <= 1'b0;
                        end
                    end else begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end

                DATA_BITS: begin
                    if (cycle_count == CNT_W'(MAX_CYCLE_CNT)) begin
                        cycle_count <= '0;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        if (bit_count == 3'd7) begin
                            state <= STOP_BIT;
                        end else begin
                            bit_count <= bit_count + 3'd1;
                        end
                    end else begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end

                // Leaving at mid-stop-bit lets an immediately following start bit be caught
                STOP_BIT: begin
                    if (cycle_count == CNT_W'(MAX_CYCLE_CNT)) begin
                        cycle_count <= '0;
                        if (rx_s) begin
                            o_RxByte  <= shift_reg;
                            o_RxValid <= 1'b1;
                            state     <= IDLE;
                            o_RxBusy  <= 1'b0;
                        end else begin
                            o_FrameErr <= 1'b1;
                            state      <= WAIT_IDLE;
                        end
                    end else begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end

                // Hold off until the line is released so a break is not read as 0x00 frames
                WAIT_IDLE: begin
                    cycle_count <= '0;
                    if (rx_s) begin
                        state    <= IDLE;
                        o_RxBusy <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    cycle_count <= '0;
                    o_RxBusy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
